dac_interface: RTL and testbench



---
 rtl/dac_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/dac_interface.sv | 112 +++++++++++
 tb/tb_dac_interface.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared definitions for the DAC transmit path.
//   - Bit positions of the two channels inside the 32-bit converter word.
//   - Streaming FSM state encoding and the underrun counter width.
//   - pack_word(): builds the converter word from one ch1/ch2 sample pair.
// Optional build macro: DAC_OFFSET_BINARY_EN. When it is defined, pack_word()
// inverts the MSB of each channel, converting two's complement to offset binary.
package dac_pkg;

    localparam int WORD_W     = 32;
    localparam int CH1_MSB    = 31;
    localparam int CH1_LSB    = 18;
    localparam int CH2_MSB    = 15;
    localparam int CH2_LSB    = 2;
    localparam int CH_W       = CH1_MSB - CH1_LSB + 1;
    localparam int UNDERRUN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // The pad bits [17:16] and [1:0] are always zero.
    function automatic logic [WORD_W-1:0] pack_word(input logic [CH_W-1:0] ch1,
                                                    input logic [CH_W-1:0] ch2);
        logic [CH_W-1:0] a;
        logic [CH_W-1:0] b;
        a = ch1;
        b = ch2;
`ifdef DAC_OFFSET_BINARY_EN
        a[CH_W-1] = ~a[CH_W-1];
        b[CH_W-1] = ~b[CH_W-1];
`endif
        pack_word                  = '0;
        pack_word[CH1_MSB:CH1_LSB] = a;
        pack_word[CH2_MSB:CH2_LSB] = b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a first-word-fall-through head.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flush        synchronous clear of pointers and level (wins over push/pop)
//   push, wdata  write one word (caller guarantees !full)
//   pop          drop the head word (caller guarantees !empty)
//   head         word at the read pointer, valid while !empty
//   full, empty  occupancy flags
//   level        current occupancy, 0..DEPTH
// DEPTH must be a power of two (at least 2), so pointers wrap naturally.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset: it is only read while level is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/dac_interface.sv
// dac_interface: buffers paired DAC samples and streams them as 32-bit
// converter words on an AXI-Stream master.
// Ports:
//   clk_design, rst     clock and synchronous active-high reset
//   en                  stream enable; low flushes everything back to IDLE
//   dac_ch1, dac_ch2    two's complement samples, qualified by sample_valid
//   sample_valid/ready  producer handshake (ready is combinational)
//   mDataAxisTdata/Tvalid/Tready   AXI-Stream master toward the DAC
//   fifo_level          current FIFO occupancy
//   underrun_cnt        saturating count of beats sent with an empty FIFO
// Optional build macro: DAC_OFFSET_BINARY_EN (offset-binary packing, see dac_pkg).
module dac_interface
    import dac_pkg::*;
#(
    parameter  int DATA_W      = 14,
    parameter  int FIFO_DEPTH  = 8,
    parameter  int PRIME_LEVEL = 2,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_design,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_W-1:0]     dac_ch1,
    input  logic [DATA_W-1:0]     dac_ch2,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic [WORD_W-1:0]     mDataAxisTdata,
    output logic                  mDataAxisTvalid,
    input  logic                  mDataAxisTready,
    output logic [LVL_W-1:0]      fifo_level,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    state_t            state;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic              push;
    logic              pop;
    logic              flush;
    logic              primed;

    assign sample_ready = en && (state != IDLE) && !fifo_full;
    assign push         = sample_valid && sample_ready;
    assign flush        = !en || (state == IDLE);
    assign primed       = (fifo_level >= LVL_W'(PRIME_LEVEL));

    // Pops happen only when the FSM below loads the head into tdata.
    // tvalid is always 1 in RUN, so tready alone marks a beat there.
    assign pop = en && (((state == PRIME) && primed) ||
                        ((state == RUN) && mDataAxisTready && !fifo_empty));

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_design),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (pack_word(dac_ch1, dac_ch2)),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk_design) begin
        if (rst) begin
            state           <= IDLE;
            mDataAxisTdata  <= '0;
            mDataAxisTvalid <= 1'b0;
            underrun_cnt    <= '0;
        end else if (!en) begin
            // Underrun history survives an enable drop; only rst clears it.
            state           <= IDLE;
            mDataAxisTdata  <= '0;
            mDataAxisTvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mDataAxisTdata  <= '0;
                    mDataAxisTvalid <= 1'b0;
                    state           <= PRIME;
                end
                PRIME: begin
                    if (primed) begin
                        mDataAxisTdata  <= fifo_head;
                        mDataAxisTvalid <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    if (mDataAxisTready) begin
                        if (!fifo_empty)
                            mDataAxisTdata <= fifo_head;
                        // Empty: the last word goes out again and is counted.
                        else if (underrun_cnt != {UNDERRUN_W{1'b1}})
                            underrun_cnt <= underrun_cnt + 1'b1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    mDataAxisTdata  <= '0;
                    mDataAxisTvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_interface.sv
// tb_dac_interface: directed, table-driven bench for dac_interface
// (defaults DATA_W=14, FIFO_DEPTH=8, PRIME_LEVEL=2).
module tb_dac_interface;

    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              clk_design = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [13:0]       dac_ch1 = '0;
    logic [13:0]       dac_ch2 = '0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic [31:0]       mDataAxisTdata;
    logic              mDataAxisTvalid;
    logic              mDataAxisTready = 1'b0;
    logic [LVL_W-1:0]  fifo_level;
    logic [15:0]       underrun_cnt;

    int errors = 0;
    int checks = 0;

    dac_interface dut (
        .clk_design      (clk_design),
        .rst             (rst),
        .en              (en),
        .dac_ch1         (dac_ch1),
        .dac_ch2         (dac_ch2),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .mDataAxisTdata  (mDataAxisTdata),
        .mDataAxisTvalid (mDataAxisTvalid),
        .mDataAxisTready (mDataAxisTready),
        .fifo_level      (fifo_level),
        .underrun_cnt    (underrun_cnt)
    );

    always #5 clk_design = ~clk_design;

    typedef struct {
        logic        en;
        logic        v;
        logic [13:0] c1;
        logic [13:0] c2;
        logic        tr;
        logic        tv;
        logic [31:0] td;
        logic        rdy;
        int          lvl;
        int          uc;
    } vec_t;

    localparam logic [31:0] W1 = 32'h48D0_2AF0; // 0x1234 / 0x0ABC
    localparam logic [31:0] W2 = 32'h0004_0008; // 0x0001 / 0x0002
    localparam logic [31:0] W3 = 32'hFFFC_FFFC; // 0x3FFF / 0x3FFF
    localparam logic [31:0] W4 = 32'h8000_0004; // 0x2000 / 0x0001
    localparam logic [31:0] W5 = 32'h3C3C_03C0; // 0x0F0F / 0x00F0

    function automatic vec_t mk(input logic e, input logic v, input logic [13:0] c1,
                                input logic [13:0] c2, input logic tr, input logic tv,
                                input logic [31:0] td, input logic rdy, input int lvl,
                                input int uc);
        vec_t r;
        r.en = e; r.v = v; r.c1 = c1; r.c2 = c2; r.tr = tr;
        r.tv = tv; r.td = td; r.rdy = rdy; r.lvl = lvl; r.uc = uc;
        return r;
    endfunction

    // Expected word for the fill/drain sequence: ch1 = ch2 = k.
    function automatic logic [31:0] kword(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return (kk << 18) | (kk << 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic tv, input logic [31:0] td,
                           input logic rdy, input int lvl, input int uc);
        chk({tag, "_tvalid"}, {31'd0, mDataAxisTvalid}, {31'd0, tv});
        chk({tag, "_tdata"},  mDataAxisTdata, td);
        chk({tag, "_ready"},  {31'd0, sample_ready}, {31'd0, rdy});
        chk({tag, "_level"},  32'(fifo_level), 32'(lvl));
        chk({tag, "_ucnt"},   32'(underrun_cnt), 32'(uc));
    endtask

    task automatic tick();
        @(posedge clk_design);
        #1;
    endtask

    task automatic drive(input logic v, input logic [13:0] c1, input logic [13:0] c2,
                         input logic tr);
        sample_valid    = v;
        dac_ch1         = c1;
        dac_ch2         = c2;
        mDataAxisTready = tr;
    endtask

    vec_t tbl [14];

    initial begin
        // Start-up, priming, first words, 5-cycle underrun, resume.
        tbl[0]  = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 32'h0, 1'b1, 0, 0);
        tbl[1]  = mk(1'b1, 1'b1, 14'h1234, 14'h0ABC, 1'b1, 1'b0, 32'h0, 1'b1, 1, 0);
        tbl[2]  = mk(1'b1, 1'b1, 14'h0001, 14'h0002, 1'b1, 1'b0, 32'h0, 1'b1, 2, 0);
        tbl[3]  = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, W1,    1'b1, 1, 0);
        tbl[4]  = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, W2,    1'b1, 0, 0);
        tbl[5]  = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, W2,    1'b1, 0, 1);
        tbl[6]  = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, W2,    1'b1, 0, 2);
        tbl[7]  = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, W2,    1'b1, 0, 3);
        tbl[8]  = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, W2,    1'b1, 0, 4);
        tbl[9]  = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, W2,    1'b1, 0, 5);
        tbl[10] = mk(1'b1, 1'b1, 14'h3FFF, 14'h3FFF, 1'b0, 1'b1, W2,    1'b1, 1, 5);
        tbl[11] = mk(1'b1, 1'b1, 14'h2000, 14'h0001, 1'b1, 1'b1, W3,    1'b1, 1, 5);
        tbl[12] = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, W4,    1'b1, 0, 5);
        tbl[13] = mk(1'b1, 1'b0, 14'h0000, 14'h0000, 1'b0, 1'b1, W4,    1'b1, 0, 5);

        // Reset state.
        tick();
        tick();
        chk_all("reset", 1'b0, 32'h0, 1'b0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en;
            drive(tbl[i].v, tbl[i].c1, tbl[i].c2, tbl[i].tr);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].tv, tbl[i].td, tbl[i].rdy,
                    tbl[i].lvl, tbl[i].uc);
        end

        // Fill to full with the sink stalled; tdata must not move.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 14'(k), 14'(k), 1'b0);
            tick();
            chk($sformatf("fill%0d_level", k), 32'(fifo_level), 32'(k));
            chk($sformatf("fill%0d_ready", k), {31'd0, sample_ready}, {31'd0, (k < 8)});
            chk($sformatf("fill%0d_tdata", k), mDataAxisTdata, W4);
        end
        drive(1'b1, 14'h3AAA, 14'h3AAA, 1'b0);
        tick();
        chk("ninth_level", 32'(fifo_level), 32'd8);
        chk("ninth_ready", {31'd0, sample_ready}, 32'd0);
        chk("ninth_tdata", mDataAxisTdata, W4);

        // Drain: exactly words 1..8 in order, then a repeat of word 8.
        drive(1'b0, 14'h0, 14'h0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("drain%0d_tdata", k), mDataAxisTdata, kword(k));
            chk($sformatf("drain%0d_level", k), 32'(fifo_level), 32'(8 - k));
        end
        tick();
        chk("drain_repeat_tdata", mDataAxisTdata, kword(8));
        chk("drain_repeat_ucnt", 32'(underrun_cnt), 32'd6);

        // Drop en with 3 words queued, then restart through PRIME.
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 14'(16 + j), 14'(16 + j), 1'b0);
            tick();
        end
        chk("queued_level", 32'(fifo_level), 32'd3);
        drive(1'b0, 14'h0, 14'h0, 1'b0);
        en = 1'b0;
        tick();
        chk_all("en_drop", 1'b0, 32'h0, 1'b0, 0, 6);
        en = 1'b1;
        tick();
        chk_all("reprime", 1'b0, 32'h0, 1'b1, 0, 6);
        drive(1'b1, 14'h0F0F, 14'h00F0, 1'b0);
        tick();
        chk_all("reprime_p1", 1'b0, 32'h0, 1'b1, 1, 6);
        drive(1'b1, 14'h1234, 14'h0ABC, 1'b0);
        tick();
        chk_all("reprime_p2", 1'b0, 32'h0, 1'b1, 2, 6);
        drive(1'b0, 14'h0, 14'h0, 1'b0);
        tick();
        chk_all("reprime_run", 1'b1, W5, 1'b1, 1, 6);

        // Reach underrun_cnt=7 in RUN, then rst mid-stream.
        drive(1'b0, 14'h0, 14'h0, 1'b1);
        tick();
        chk_all("pre_rst_a", 1'b1, W1, 1'b1, 0, 6);
        tick();
        chk_all("pre_rst_b", 1'b1, W1, 1'b1, 0, 7);
        rst = 1'b1;
        tick();
        chk_all("mid_rst", 1'b0, 32'h0, 1'b0, 0, 0);
        rst = 1'b0;

        // Packing of extreme values (offset binary when the macro is set).
        drive(1'b0, 14'h0, 14'h0, 1'b0);
        tick();
        drive(1'b1, 14'h3FFF, 14'h2000, 1'b0);
        tick();
        drive(1'b1, 14'h0001, 14'h0002, 1'b0);
        tick();
        drive(1'b0, 14'h0, 14'h0, 1'b0);
        tick();
`ifdef DAC_OFFSET_BINARY_EN
        chk("pack_extreme_tdata", mDataAxisTdata, 32'h7FFC_0000);
`else
        chk("pack_extreme_tdata", mDataAxisTdata, 32'hFFFC_8000);
`endif
        chk("pack_extreme_tvalid", {31'd0, mDataAxisTvalid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
